// File: rtl/rks_loader_pkg.sv
// rks_pkg: shared FSM state, error codes and header size for the RKS tape loader
package rks_pkg;

    localparam int HDR_BYTES = 4;

    typedef enum logic [3:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        HDR3,
        DATA,
        CS_LO,
        CS_HI,
        TRAIL,
        DONE,
        ERR
    } rks_state_t;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_HDR   = 3'd1,
        ERR_RANGE = 3'd2,
        ERR_TRUNC = 3'd3,
        ERR_CKSUM = 3'd4
    } rks_err_t;

endpackage

// File: rtl/rks_loader_cksum.sv
// rks_cksum: 16-bit RKS checksum accumulator; the final payload byte only adds into the low byte
module rks_cksum (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic        i_last,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_sum
);
    logic [8:0] w_lo;
    logic [7:0] w_hi;

    assign w_lo = {1'b0, o_sum[7:0]} + {1'b0, i_byte};
    assign w_hi = i_last ? o_sum[15:8] : o_sum[15:8] + i_byte + {7'd0, w_lo[8]};

    // accumulate one payload byte per enable, cleared at the start of every download
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear)
            o_sum <= 16'd0;
        else if (i_en)
            o_sum <= {w_hi, w_lo[7:0]};
    end
endmodule

// File: rtl/rks_loader.sv
// rks_loader: parses an RKS tape image from the ioctl download channel and writes its payload to RAM
// Optional checksum verification is built when RKS_LOADER_CKSUM_EN is defined.
module rks_loader
    import rks_pkg::*;
#(
    parameter logic [15:0] TOP_ADDR    = 16'hC000,
    parameter logic [24:0] BASE_OFFSET = 25'h0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [7:0]  dl_data,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        run_pulse,
    output logic [15:0] start_addr,
    output logic [2:0]  err
);
    rks_state_t  r_state;
    rks_err_t    r_err;
    logic        r_act;
    logic [15:0] r_start;
    logic [15:0] r_end;
    logic [15:0] r_cur;
    logic [24:0] r_addr;
    logic [7:0]  r_dout;
    logic        r_we;
    logic        r_done;
    logic        r_run;
    logic        w_rise;
    logic        w_fall;
    logic        w_byte;
    logic        w_last;
    logic        w_cs_ok;

    assign w_rise = dl_active & ~r_act;
    assign w_fall = ~dl_active & r_act;
    assign w_byte = dl_active & dl_wr & ~w_rise;
    assign w_last = r_cur == r_end;

`ifdef RKS_LOADER_CKSUM_EN
    logic [15:0] w_sum;
    logic [7:0]  r_cs_lo;
    logic [7:0]  r_cs_hi;

    rks_cksum u_cksum (
        .i_clk   (clk_sys),
        .i_rst   (reset),
        .i_clear (w_rise),
        .i_en    (w_byte && r_state == DATA && r_cur < TOP_ADDR),
        .i_last  (w_last),
        .i_byte  (dl_data),
        .o_sum   (w_sum)
    );

    // capture the checksum stored in the file trailer
    always_ff @(posedge clk_sys) begin
        if (reset || w_rise) begin
            r_cs_lo <= 8'd0;
            r_cs_hi <= 8'd0;
        end else if (w_byte) begin
            r_cs_lo <= r_state == CS_LO ? dl_data : r_cs_lo;
            r_cs_hi <= r_state == CS_HI ? dl_data : r_cs_hi;
        end
    end

    assign w_cs_ok = w_sum == {r_cs_hi, r_cs_lo};
`else
    assign w_cs_ok = 1'b1;
`endif

    // parser FSM: header, payload writes with one-cycle latency, trailer, and end-of-download verdict
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
            r_err   <= ERR_NONE;
            r_act   <= 1'b0;
            r_start <= 16'd0;
            r_end   <= 16'd0;
            r_cur   <= 16'd0;
            r_addr  <= 25'd0;
            r_dout  <= 8'd0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_act <= dl_active;
            r_we  <= 1'b0;
            r_run <= 1'b0;
            if (w_rise) begin
                r_state <= HDR0;
                r_err   <= ERR_NONE;
                r_start <= 16'd0;
                r_done  <= 1'b0;
            end else if (w_byte) begin
                case (r_state)
                    HDR0: begin
                        r_start[7:0] <= dl_data;
                        r_state      <= HDR1;
                    end
                    HDR1: begin
                        r_start[15:8] <= dl_data;
                        r_state       <= HDR2;
                    end
                    HDR2: begin
                        r_end[7:0] <= dl_data;
                        r_state    <= HDR3;
                    end
                    HDR3: begin
                        r_end[15:8] <= dl_data;
                        if ({dl_data, r_end[7:0]} < r_start) begin
                            r_state <= ERR;
                            r_err   <= ERR_HDR;
                        end else begin
                            r_cur   <= r_start;
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        if (r_cur >= TOP_ADDR) begin
                            r_state <= ERR;
                            r_err   <= ERR_RANGE;
                        end else begin
                            r_we    <= 1'b1;
                            r_addr  <= BASE_OFFSET + {9'd0, r_cur};
                            r_dout  <= dl_data;
                            r_state <= w_last ? CS_LO : DATA;
                            r_cur   <= w_last ? r_cur : r_cur + 16'd1;
                        end
                    end
                    CS_LO: r_state <= CS_HI;
                    CS_HI: r_state <= TRAIL;
                    default: ;
                endcase
            end else if (w_fall) begin
                if (r_state == TRAIL) begin
                    r_state <= w_cs_ok ? DONE : ERR;
                    r_err   <= w_cs_ok ? ERR_NONE : ERR_CKSUM;
                    r_done  <= w_cs_ok;
                    r_run   <= w_cs_ok;
                end else if (busy) begin
                    r_state <= ERR;
                    r_err   <= ERR_TRUNC;
                end
            end
        end
    end

    assign busy       = r_state inside {HDR0, HDR1, HDR2, HDR3, DATA, CS_LO, CS_HI, TRAIL};
    assign mem_addr   = r_addr;
    assign mem_dout   = r_dout;
    assign mem_we     = r_we;
    assign done       = r_done;
    assign run_pulse  = r_run;
    assign start_addr = r_start;
    assign err        = r_err;
endmodule
